// File: rtl/lfsr_prn_checker.sv
// Receive-side PRN checker: self-synchronises a local LFSR copy, then counts bits, errors and
// zero runs. Define LFSR_CHK_BCD_EN to add the err_ones/err_tens BCD display outputs.
module lfsr_prn_checker #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  TAPS       = 32'h80200003,
  parameter int unsigned       LOCK_CNT   = 64,
  parameter int unsigned       ERR_THRESH = 4,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       RUN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
`ifdef LFSR_CHK_BCD_EN
  output logic [3:0]       err_ones,
  output logic [3:0]       err_tens,
`endif
  output logic [RUN_W-1:0] max_zero_run
);

  localparam int unsigned FillW  = $clog2(WIDTH + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(ERR_THRESH + 1);

  localparam logic [FillW-1:0]  FillLast  = FillW'(WIDTH - 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [WinW-1:0]   WinLast   = WinW'(ERR_THRESH - 1);

  typedef enum logic [1:0] {StFill, StVerify, StLocked} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [FillW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
  logic [WinW-1:0]    err_win_q, err_win_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [RUN_W-1:0]   cur_run_q, cur_run_d;
  logic [RUN_W-1:0]   max_run_q, max_run_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               pred;
  logic               mismatch;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  assign pred     = ^(r_q & TAPS);
  assign mismatch = din ^ pred;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    err_win_d   = err_win_q;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    cur_run_d   = cur_run_q;
    max_run_d   = max_run_q;
    err_pulse_d = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StFill: begin
          r_d = {r_q[WIDTH-2:0], din};
          if (fill_cnt_q == FillLast) begin
            fill_cnt_d = '0;
            // An all-zero register is the LFSR lock-up state; keep filling.
            if (r_d != '0) state_d = StVerify;
          end else begin
            fill_cnt_d = fill_cnt_q + FillW'(1);
          end
        end
        StVerify: begin
          r_d = {r_q[WIDTH-2:0], din};
          if (mismatch) begin
            state_d     = StFill;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_q == MatchLast) begin
            state_d     = StLocked;
            match_cnt_d = '0;
            err_win_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MatchW'(1);
          end
        end
        StLocked: begin
          // Free-run on the prediction so corrupted bits never enter the model.
          r_d         = {r_q[WIDTH-2:0], pred};
          bit_count_d = sat_cnt(bit_count_q);
          if (mismatch) begin
            err_count_d = sat_cnt(err_count_q);
            err_pulse_d = 1'b1;
            match_cnt_d = '0;
            if (err_win_q == WinLast) begin
              state_d    = StFill;
              fill_cnt_d = '0;
              err_win_d  = '0;
            end else begin
              err_win_d = err_win_q + WinW'(1);
            end
          end else if (match_cnt_q == MatchLast) begin
            match_cnt_d = '0;
            err_win_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MatchW'(1);
          end
        end
        default: state_d = StFill;
      endcase

      cur_run_d = din ? '0 : sat_run(cur_run_q);
      if (cur_run_d > max_run_q) max_run_d = cur_run_d;
    end

    if (clear) begin
      bit_count_d = '0;
      err_count_d = '0;
      cur_run_d   = '0;
      max_run_d   = '0;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StFill;
      r_q         <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      err_win_q   <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
      cur_run_q   <= '0;
      max_run_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_win_q   <= err_win_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
      cur_run_q   <= cur_run_d;
      max_run_q   <= max_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign bit_count    = bit_count_q;
  assign err_count    = err_count_q;
  assign max_zero_run = max_run_q;

`ifdef LFSR_CHK_BCD_EN
  logic [6:0] err_cap;
  logic [3:0] err_ones_q, err_ones_d;
  logic [3:0] err_tens_q, err_tens_d;

  always_comb begin
    err_cap    = (err_count_q > CNT_W'(99)) ? 7'd99 : err_count_q[6:0];
    err_tens_d = 4'(err_cap / 7'd10);
    err_ones_d = 4'(err_cap % 7'd10);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_ones_q <= '0;
      err_tens_q <= '0;
    end else begin
      err_ones_q <= err_ones_d;
      err_tens_q <= err_tens_d;
    end
  end

  assign err_ones = err_ones_q;
  assign err_tens = err_tens_q;
`endif

endmodule
